// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 3-sample majority vote, parity/framing/overrun flags,
// break detection and a valid/ready output handshake.
//   S_IDLE   | line idle, waiting for a falling edge
//   S_START  | validating the start bit (false-start rejection)
//   S_DATA   | sampling DATA_W data bits, LSB first
//   S_PARITY | sampling and checking the parity bit
//   S_STOP   | sampling stop bits; word delivered on the last stop decision
//   S_BREAK  | line held low for a whole frame; waiting for it to recover
module uart_rx_param #(
  parameter int DATA_W    = 8,
  parameter int OVS       = 16,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_en,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              break_det
);

  localparam int TW = $clog2(OVS);
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] T_S0  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OVS / 2);
  localparam logic [TW-1:0] T_DEC = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVS - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_W - 1);
  localparam logic [IW-1:0] I_STOP = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t              state_q;
  logic                rx_meta_q, rxs_q;
  logic [TW-1:0]       tick_q;
  logic [IW-1:0]       idx_q;
  logic                s0_q, s1_q;
  logic [DATA_W-1:0]   shift_q;
  logic                par_bit_q, par_flag_q, frm_flag_q, stop_hi_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic                rx_valid_q, par_err_q, frm_err_q, ovr_q, brk_q;

  logic maj, at_dec, par_exp, frm_fin, stop_hi_fin, is_break;

  assign maj         = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
  assign at_dec      = (tick_q == T_DEC);
  assign par_exp     = (PARITY == 2) ? ~(^shift_q) : (^shift_q);
  assign frm_fin     = frm_flag_q | ~maj;
  assign stop_hi_fin = stop_hi_q | maj;
  // A break is an all-zero frame: data, parity sample and every stop sample low.
  assign is_break    = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !stop_hi_fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      idx_q      <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_flag_q <= 1'b0;
      frm_flag_q <= 1'b0;
      stop_hi_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      ovr_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      brk_q <= 1'b0;
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
        rx_data_q  <= '0;
        par_err_q  <= 1'b0;
        frm_err_q  <= 1'b0;
      end
      if (!rx_en) begin
        state_q <= S_IDLE;
        tick_q  <= '0;
        idx_q   <= '0;
      end else begin
        if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
          tick_q <= (tick_q == T_END) ? '0 : tick_q + 1'b1;
          if (tick_q == T_S0) s0_q <= rxs_q;
          if (tick_q == T_S1) s1_q <= rxs_q;
        end
        case (state_q)
          S_IDLE: begin
            if (!rxs_q) begin
              state_q    <= S_START;
              tick_q     <= '0;
              idx_q      <= '0;
              par_bit_q  <= 1'b0;
              par_flag_q <= 1'b0;
              frm_flag_q <= 1'b0;
              stop_hi_q  <= 1'b0;
            end
          end
          S_START: begin
            if (at_dec && maj) begin
              state_q <= S_IDLE;
              tick_q  <= '0;
            end else if (tick_q == T_END) begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end
          end
          S_DATA: begin
            if (at_dec) shift_q <= {maj, shift_q[DATA_W-1:1]};
            if (tick_q == T_END) begin
              if (idx_q == I_LAST) begin
                idx_q   <= '0;
                state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end
          S_PARITY: begin
            if (at_dec) begin
              par_bit_q  <= maj;
              par_flag_q <= (maj != par_exp);
            end
            if (tick_q == T_END) state_q <= S_STOP;
          end
          S_STOP: begin
            if (tick_q == T_END) idx_q <= idx_q + 1'b1;
            if (at_dec) begin
              if (idx_q == I_STOP) begin
                // Leave at mid-bit so the next start edge is never missed.
                state_q <= S_IDLE;
                tick_q  <= '0;
                idx_q   <= '0;
                if (is_break) begin
                  brk_q   <= 1'b1;
                  state_q <= S_BREAK;
                end else if (rx_valid_q && !rx_ready) begin
                  ovr_q <= 1'b1;
                end else begin
                  rx_valid_q <= 1'b1;
                  rx_data_q  <= shift_q;
                  par_err_q  <= par_flag_q;
                  frm_err_q  <= frm_fin;
                end
              end else begin
                frm_flag_q <= frm_fin;
                stop_hi_q  <= stop_hi_fin;
              end
            end
          end
          S_BREAK: begin
            if (!rxs_q) begin
              tick_q <= '0;
            end else if (tick_q == T_S0) begin
              state_q <= S_IDLE;
              tick_q  <= '0;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign parity_err  = par_err_q;
  assign frame_err   = frm_err_q;
  assign overrun_err = ovr_q;
  assign break_det   = brk_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two configurations (8E1 x16 and 7O2 x8) driven with directed
// and random frames; delivered words are checked against a queue of words the bench sent.
module tb_uart_rx_param;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic [1:0] rstn, en, rxp, rdy;
  logic       rand_rdy;
  int         cyc = 0;
  int         n_cmp = 0, n_bad = 0;

  logic [7:0] dat_a;
  logic [6:0] dat_b;
  logic vld_a, vld_b, busy_a, busy_b, pe_a, pe_b, fe_a, fe_b, ov_a, ov_b, bk_a, bk_b;

  exp_t        q0[$], q1[$];
  logic [10:0] lw[2];
  int          lw_cyc[2], st_cyc[2], n_words[2], n_ovr[2], n_brk[2];
  logic [1:0]  pv, pr;
  exp_t        cur[2];

  uart_rx_param #(.DATA_W(8), .OVS(16), .PARITY(1), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rstn[0]), .rx_en(en[0]), .rx(rxp[0]), .rx_data(dat_a),
    .rx_valid(vld_a), .rx_ready(rdy[0]), .busy(busy_a), .parity_err(pe_a),
    .frame_err(fe_a), .overrun_err(ov_a), .break_det(bk_a));

  uart_rx_param #(.DATA_W(7), .OVS(8), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .rst_n(rstn[1]), .rx_en(en[1]), .rx(rxp[1]), .rx_data(dat_b),
    .rx_valid(vld_b), .rx_ready(rdy[1]), .busy(busy_b), .parity_err(pe_b),
    .frame_err(fe_b), .overrun_err(ov_b), .break_det(bk_b));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish within time budget");
    $fatal(1);
  end

  function automatic int dwf(input int u); return (u == 0) ? 8 : 7; endfunction
  function automatic int ovsf(input int u); return (u == 0) ? 16 : 8; endfunction
  function automatic int parf(input int u); return (u == 0) ? 1 : 2; endfunction
  function automatic int stf(input int u); return (u == 0) ? 1 : 2; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit pop_exp(input int u, output exp_t e);
    e = '0;
    if (u == 0) begin
      if (q0.size() == 0) return 1'b0;
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) return 1'b0;
      e = q1.pop_front();
    end
    return 1'b1;
  endfunction

  // Serialises one frame onto unit u's pin; spike flips one clock at a data bit's centre.
  task automatic send_frame(input int u, input logic [8:0] d_in, input bit bad_par,
                            input bit bad_stop, input int spike, input bit deliver);
    int dw, ovs, par, nb;
    logic [8:0] d;
    logic pb, b;
    exp_t e;
    dw  = dwf(u);
    ovs = ovsf(u);
    par = parf(u);
    nb  = 1 + dw + ((par != 0) ? 1 : 0) + stf(u);
    d   = d_in & 9'((1 << dw) - 1);
    pb  = ^d;
    if (par == 2) pb = ~pb;
    pb  = pb ^ bad_par;
    e.d = d;
    e.pe = bad_par && (par != 0);
    e.fe = bad_stop;
    if (deliver) begin
      if (u == 0) q0.push_back(e); else q1.push_back(e);
    end
    for (int k = 0; k < nb; k++) begin
      if (k == 0) b = 1'b0;
      else if (k <= dw) b = d[k-1];
      else if (par != 0 && k == dw + 1) b = pb;
      else b = !(bad_stop && k == dw + 1 + ((par != 0) ? 1 : 0));
      for (int j = 0; j < ovs; j++) begin
        rxp[u] = b ^ ((k >= 1) && (k <= dw) && (spike == k - 1) && (j == ovs / 2 + 1));
        if (k == 0 && j == 0) st_cyc[u] = cyc + 1;
        step(1);
      end
    end
    rxp[u] = 1'b1;
  endtask

  task automatic rand_frames(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      logic [8:0] d;
      bit bp, bs;
      int sp;
      d  = 9'($urandom_range(0, (1 << dwf(u)) - 1));
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0) && (d != 0);
      sp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, dwf(u) - 1)) : -1;
      send_frame(u, d, bp, bs, sp, 1'b1);
      step((bs ? 2 * ovsf(u) : 0) + int'($urandom_range(0, 12)));
    end
  endtask

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      rdy = 2'($urandom_range(0, 3));
    end
  end

  // Compare process: every new word must match the head of the model queue, a held word
  // must stay put, and outputs must read zero whenever nothing is held.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic [10:0] obs;
      logic v;
      exp_t e;
      obs = (u == 0) ? {1'b0, dat_a, pe_a, fe_a} : {2'b0, dat_b, pe_b, fe_b};
      v   = (u == 0) ? vld_a : vld_b;
      if (!rstn[u]) begin
        pv[u] = 1'b0;
        pr[u] = 1'b0;
      end else begin
        if ((u == 0) ? ov_a : ov_b) n_ovr[u]++;
        if ((u == 0) ? bk_a : bk_b) n_brk[u]++;
        if (v && (!pv[u] || pr[u])) begin
          lw[u] = obs;
          lw_cyc[u] = cyc;
          n_words[u]++;
          if (pop_exp(u, e)) begin
            cur[u] = e;
            chk((u == 0) ? "word a" : "word b", 32'(obs), 32'(e));
          end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected word on unit %0d: got 0x%0h, expected no word", u, obs);
          end
        end else if (v) begin
          chk((u == 0) ? "held a" : "held b", 32'(obs), 32'(cur[u]));
        end else begin
          chk((u == 0) ? "idle a" : "idle b", 32'(obs), 32'd0);
        end
        pv[u] = v;
        pr[u] = rdy[u];
      end
    end
  end

  initial begin
    bit saw;
    int w0;
    rstn = 2'b00; en = 2'b11; rxp = 2'b11; rdy = 2'b11; rand_rdy = 1'b0;
    pv = '0; pr = '0;
    for (int u = 0; u < 2; u++) begin
      n_words[u] = 0; n_ovr[u] = 0; n_brk[u] = 0; lw[u] = '0; lw_cyc[u] = 0; st_cyc[u] = 0;
      cur[u] = '0;
    end
    step(3);
    chk("reset a", 32'({dat_a, vld_a, busy_a, pe_a, fe_a, ov_a, bk_a}), 32'd0);
    chk("reset b", 32'({dat_b, vld_b, busy_b, pe_b, fe_b, ov_b, bk_b}), 32'd0);
    rstn = 2'b11;
    step(5);

    // 0xA5 even parity: four ones, parity bit 0. Latency: pin edge E0, 2 sync flops,
    // START one clock later, decision at tick 9 of stop bit 10, one-cycle load = 172.
    send_frame(0, 9'h0A5, 1'b0, 1'b0, -1, 1'b1);
    step(4);
    chk("t1 word", 32'(lw[0]), 32'({9'h0A5, 1'b0, 1'b0}));
    chk("t1 latency", 32'(lw_cyc[0] - st_cyc[0]), 32'd172);

    send_frame(0, 9'h0A5, 1'b1, 1'b0, -1, 1'b1);
    step(4);
    chk("t2 parity word", 32'(lw[0]), 32'({9'h0A5, 1'b1, 1'b0}));
    send_frame(0, 9'h03C, 1'b0, 1'b1, -1, 1'b1);
    step(4);
    chk("t2 frame word", 32'(lw[0]), 32'({9'h03C, 1'b0, 1'b1}));
    step(40);

    w0 = n_words[0];
    saw = 1'b0;
    rxp[0] = 1'b0;
    step(5);
    rxp[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (busy_a) saw = 1'b1;
      step(1);
    end
    chk("t3 busy seen", 32'(saw), 32'd1);
    chk("t3 busy idle", 32'(busy_a), 32'd0);
    chk("t3 no word", 32'(n_words[0] - w0), 32'd0);

    rdy[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 1'b0, -1, 1'b1);
    step(2);
    send_frame(0, 9'h022, 1'b0, 1'b0, -1, 1'b0);
    step(4);
    chk("t4 held word", 32'({vld_a, dat_a}), 32'({1'b1, 8'h11}));
    chk("t4 overrun pulses", 32'(n_ovr[0]), 32'd1);
    rdy[0] = 1'b1;
    step(1);
    chk("t4 valid drop", 32'(vld_a), 32'd0);

    w0 = n_words[0];
    rxp[0] = 1'b0;
    step(352);
    rxp[0] = 1'b1;
    step(4);
    chk("t5 break hold busy", 32'(busy_a), 32'd1);
    for (int i = 0; i < 12 && busy_a; i++) step(1);
    chk("t5 break release busy", 32'(busy_a), 32'd0);
    chk("t5 break pulses", 32'(n_brk[0]), 32'd1);
    chk("t5 no word", 32'({vld_a, 8'(n_words[0] - w0)}), 32'd0);
    step(4);
    send_frame(0, 9'h05A, 1'b0, 1'b0, -1, 1'b1);
    step(4);
    chk("t5 word after break", 32'(lw[0]), 32'({9'h05A, 1'b0, 1'b0}));

    rdy[1] = 1'b0;
    send_frame(1, 9'h055, 1'b0, 1'b0, 3, 1'b1);
    step(3);
    chk("t6 spike word", 32'(lw[1]), 32'({9'h055, 1'b0, 1'b0}));
    chk("t6 held valid", 32'(vld_b), 32'd1);
    fork
      send_frame(1, 9'h02A, 1'b0, 1'b0, -1, 1'b0);
      begin
        step(30);
        chk("t6 busy before reset", 32'(busy_b), 32'd1);
        rstn[1] = 1'b0;
        #1;
        chk("t6 reset outputs", 32'({dat_b, vld_b, busy_b, pe_b, fe_b, ov_b, bk_b}), 32'd0);
      end
    join
    rstn[1] = 1'b1;
    rdy[1] = 1'b1;
    step(10);

    w0 = n_words[0];
    fork
      send_frame(0, 9'h077, 1'b0, 1'b0, -1, 1'b0);
      begin
        step(60);
        en[0] = 1'b0;
        step(1);
        chk("t7 disable busy", 32'(busy_a), 32'd0);
      end
    join
    step(5);
    en[0] = 1'b1;
    step(5);
    chk("t7 dropped frame", 32'(n_words[0] - w0), 32'd0);

    rand_rdy = 1'b1;
    fork
      rand_frames(0, 30);
      rand_frames(1, 40);
    join
    rand_rdy = 1'b0;
    rdy = 2'b11;
    step(50);
    chk("queue a drained", 32'(q0.size()), 32'd0);
    chk("queue b drained", 32'(q1.size()), 32'd0);
    chk("overrun totals", 32'({8'(n_ovr[0]), 8'(n_ovr[1])}), 32'h0100);
    chk("break totals", 32'({8'(n_brk[0]), 8'(n_brk[1])}), 32'h0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
